// File: rtl/block_padder.sv
// Block padder: packs IW-bit message words into RATE-bit blocks and pads the tail (0x01 after the message, 0x80 in the last block byte).
// Latency: a word accepted at edge k is in `out` after edge k; out_ready rises after the edge that writes word N.
// Backpressure: buffer_full while a complete block awaits f_ack, or while padding / holding the final block.
// Ports: clk, reset_n (async, active-low); in, in_ready, is_last, byte_num carry message words;
//        buffer_full says an offered word is refused; out, out_ready, last_block present the block;
//        f_ack is the one-cycle pulse from the consumer that the block was taken.
module block_padder #(
  parameter int IW   = 64,
  parameter int RATE = 576
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [IW-1:0]   in,
  input  logic            in_ready,
  input  logic            is_last,
  input  logic [3:0]      byte_num,
  output logic            buffer_full,
  output logic [RATE-1:0] out,
  output logic            out_ready,
  output logic            last_block,
  input  logic            f_ack
);

  localparam int         NB   = IW / 8;
  localparam logic [5:0] N    = 6'(RATE / IW);
  localparam logic [5:0] N_M1 = 6'(RATE / IW - 1);

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    PAD    = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [5:0]    cnt;
  logic          full;
  logic          accept;
  logic          pad_shift;
  logic          shift;
  logic          ack_clr;
  logic [4:0]    bn_eff;
  logic [IW-1:0] last_w;
  logic [IW-1:0] w;

  assign full      = (cnt == N);
  assign accept    = in_ready & ~buffer_full & (state == ACCEPT);
  // Padding never runs into a full block; it waits for f_ack and resumes.
  assign pad_shift = (state == PAD) & ~full;
  assign shift     = accept | pad_shift;
  // f_ack only matters while a complete block is presented.
  assign ack_clr   = f_ack & full;

  // Final partial word: keep the top bn_eff bytes, then 0x01, then zeros.
  // When it is also the last word of the block the closing 0x80 bit lands here too.
  always_comb begin
    bn_eff = ({1'b0, byte_num} >= 5'(NB)) ? 5'd0 : {1'b0, byte_num};
    last_w = '0;
    for (int i = 0; i < NB; i++) begin
      if (5'(i) < bn_eff) begin
        last_w[IW-1-8*i -: 8] = in[IW-1-8*i -: 8];
      end else if (5'(i) == bn_eff) begin
        last_w[IW-1-8*i -: 8] = 8'h01;
      end
    end
    if (cnt == N_M1) begin
      last_w[7] = 1'b1;
    end
  end

  always_comb begin
    if (state == PAD) begin
      w = (cnt == N_M1) ? {{(IW-8){1'b0}}, 8'h80} : '0;
    end else if (is_last) begin
      w = last_w;
    end else begin
      w = in;
    end
  end

  // Datapath: shift register and word counter. `out` keeps its contents on f_ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out <= '0;
      cnt <= '0;
    end else if (shift) begin
      out <= (out << IW) | RATE'(w);
      cnt <= cnt + 6'd1;
    end else if (ack_clr) begin
      cnt <= '0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ACCEPT;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      ACCEPT:  if (accept && is_last) state_nxt = (cnt == N_M1) ? DONE : PAD;
      PAD:     if (pad_shift && (cnt == N_M1)) state_nxt = DONE;
      DONE:    if (ack_clr) state_nxt = ACCEPT;
      default: state_nxt = ACCEPT;
    endcase
  end

  // FSM outputs, decoded from registers only
  always_comb begin
    out_ready   = full;
    buffer_full = full | (state != ACCEPT);
    last_block  = full & (state == DONE);
  end

endmodule

// File: tb/tb_block_padder.sv
module tb_block_padder;

  localparam int IW   = 64;
  localparam int RATE = 576;
  localparam int N    = RATE / IW;
  localparam int NB   = IW / 8;
  localparam int RB   = RATE / 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [IW-1:0]   in;
  logic            in_ready;
  logic            is_last;
  logic [3:0]      byte_num;
  logic            buffer_full;
  logic [RATE-1:0] out;
  logic            out_ready;
  logic            last_block;
  logic            f_ack;

  int n_cmp = 0;
  int n_err = 0;

  logic [IW-1:0]   msg_q[$];
  logic [RATE-1:0] exp_blk[$];
  bit              exp_lst[$];

  always #5 clk = ~clk;

  block_padder #(.IW(IW), .RATE(RATE)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in         (in),
    .in_ready   (in_ready),
    .is_last    (is_last),
    .byte_num   (byte_num),
    .buffer_full(buffer_full),
    .out        (out),
    .out_ready  (out_ready),
    .last_block (last_block),
    .f_ack      (f_ack)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RATE-1:0] pack(input logic [IW-1:0] wa [N]);
    logic [RATE-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r = (r << IW) | RATE'(wa[i]);
    return r;
  endfunction

  // Reference model: message as a byte stream, append 0x01, zero-fill to a
  // whole number of blocks, OR 0x80 into the very last byte, then slice.
  task automatic build_expected(input logic [IW-1:0] lw, input int bn);
    byte unsigned    bq[$];
    int              eff;
    int              nblk;
    logic [RATE-1:0] b;
    bq = {};
    exp_blk = {};
    exp_lst = {};
    foreach (msg_q[i])
      for (int j = NB - 1; j >= 0; j--) bq.push_back(msg_q[i][8*j +: 8]);
    eff = (bn >= NB) ? 0 : bn;
    for (int j = 0; j < eff; j++) bq.push_back(lw[IW-1-8*j -: 8]);
    bq.push_back(8'h01);
    while (bq.size() % RB != 0) bq.push_back(8'h00);
    bq[bq.size()-1] = bq[bq.size()-1] | 8'h80;
    nblk = bq.size() / RB;
    for (int k = 0; k < nblk; k++) begin
      b = '0;
      for (int j = 0; j < RB; j++) b = {b[RATE-9:0], bq[k*RB+j]};
      exp_blk.push_back(b);
      exp_lst.push_back(k == nblk - 1);
    end
  endtask

  // Offer one word and hold it until the edge that accepts it.
  task automatic drive_word(input logic [IW-1:0] wd, input logic lst, input logic [3:0] bn);
    int t;
    t = 0;
    in = wd; is_last = lst; byte_num = bn; in_ready = 1'b1;
    while (buffer_full && t < 300) begin
      step();
      t++;
    end
    if (t >= 300) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: buffer_full=%b after 300 cycles, required 0", buffer_full);
    end
    step();
    in_ready = 1'b0; is_last = 1'b0;
  endtask

  task automatic idle_gap();
    in_ready = 1'b0;
    in = {$urandom, $urandom};
    repeat ($urandom_range(0, 2)) step();
  endtask

  task automatic consume_blocks(input int nb);
    int t;
    int d;
    for (int b = 0; b < nb; b++) begin
      t = 0;
      while (!out_ready && t < 500) begin
        step();
        t++;
      end
      n_cmp++;
      if (out_ready !== 1'b1) begin
        n_err++;
        $display("FAIL block_timeout: block %0d out_ready=%b, required 1", b, out_ready);
        return;
      end
      n_cmp++;
      if (out !== exp_blk[b]) begin
        n_err++;
        $display("FAIL block_data: block %0d got %h required %h", b, out, exp_blk[b]);
      end
      n_cmp++;
      if (last_block !== exp_lst[b]) begin
        n_err++;
        $display("FAIL block_last: block %0d last_block=%b required %b", b, last_block, exp_lst[b]);
      end
      d = $urandom_range(0, 5);
      repeat (d) step();
      n_cmp++;
      if (buffer_full !== 1'b1 || out_ready !== 1'b1) begin
        n_err++;
        $display("FAIL block_hold: after %0d waits buffer_full=%b out_ready=%b, required 1/1", d, buffer_full, out_ready);
      end
      f_ack = 1'b1;
      step();
      f_ack = 1'b0;
      n_cmp++;
      if (out_ready !== 1'b0) begin
        n_err++;
        $display("FAIL ack_clear: block %0d out_ready=%b after f_ack, required 0", b, out_ready);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in = '0; in_ready = 1'b0; is_last = 1'b0; byte_num = '0; f_ack = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++;
    if (out !== '0) begin n_err++; $display("FAIL reset_out: got %h required 0", out); end
    n_cmp++;
    if (buffer_full !== 1'b0) begin n_err++; $display("FAIL reset_buffer_full: got %b required 0", buffer_full); end
    n_cmp++;
    if (out_ready !== 1'b0) begin n_err++; $display("FAIL reset_out_ready: got %b required 0", out_ready); end
    n_cmp++;
    if (last_block !== 1'b0) begin n_err++; $display("FAIL reset_last_block: got %b required 0", last_block); end
    #1 reset_n = 1'b1;
    step();
  endtask

  // Nine full words, stall while full, then an is_last word offered in the
  // same cycle as f_ack: it must wait one cycle and then pad a whole block.
  task automatic test_full_block();
    logic [IW-1:0]   ew [N];
    logic [RATE-1:0] blk;
    int              t;
    for (int i = 0; i < N; i++) begin
      ew[i] = IW'(i + 1);
      drive_word(ew[i], 1'b0, 4'd0);
    end
    blk = pack(ew);
    n_cmp++;
    if (out_ready !== 1'b1 || last_block !== 1'b0) begin
      n_err++; $display("FAIL full_flags: out_ready=%b last_block=%b required 1/0", out_ready, last_block);
    end
    n_cmp++;
    if (out !== blk) begin n_err++; $display("FAIL full_data: got %h required %h", out, blk); end
    in_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in = {$urandom, $urandom};
      step();
      n_cmp++;
      if (buffer_full !== 1'b1 || out !== blk) begin
        n_err++; $display("FAIL full_stall: cycle %0d buffer_full=%b out=%h required 1/%h", i, buffer_full, out, blk);
      end
    end
    in = {$urandom, $urandom}; is_last = 1'b1; byte_num = 4'd0; f_ack = 1'b1;
    n_cmp++;
    if (buffer_full !== 1'b1) begin n_err++; $display("FAIL coincide_refuse: buffer_full=%b required 1", buffer_full); end
    step();
    f_ack = 1'b0;
    n_cmp++;
    if (out_ready !== 1'b0 || buffer_full !== 1'b0 || out !== blk) begin
      n_err++;
      $display("FAIL coincide_after_ack: out_ready=%b buffer_full=%b out=%h required 0/0/%h", out_ready, buffer_full, out, blk);
    end
    step();
    in_ready = 1'b0; is_last = 1'b0;
    n_cmp++;
    if (buffer_full !== 1'b1 || out_ready !== 1'b0) begin
      n_err++; $display("FAIL coincide_pad_entry: buffer_full=%b out_ready=%b required 1/0", buffer_full, out_ready);
    end
    t = 0;
    while (!out_ready && t < 20) begin step(); t++; end
    n_cmp++;
    if (t != N - 1) begin n_err++; $display("FAIL coincide_pad_cycles: got %0d required %0d", t, N - 1); end
    for (int i = 0; i < N; i++) ew[i] = '0;
    ew[0] = 64'h0100000000000000;
    ew[N-1] = 64'h80;
    blk = pack(ew);
    n_cmp++;
    if (out !== blk || last_block !== 1'b1) begin
      n_err++; $display("FAIL coincide_block: out=%h last=%b required %h/1", out, last_block, blk);
    end
    f_ack = 1'b1; step(); f_ack = 1'b0;
    n_cmp++;
    if (out_ready !== 1'b0 || buffer_full !== 1'b0) begin
      n_err++; $display("FAIL coincide_release: out_ready=%b buffer_full=%b required 0/0", out_ready, buffer_full);
    end
  endtask

  // Two words then a 3-byte tail: 6 padding cycles that ignore in_ready.
  task automatic test_pad();
    logic [IW-1:0]   ew [N];
    logic [RATE-1:0] blk;
    int              t;
    int              bf_low;
    for (int i = 0; i < N; i++) ew[i] = '0;
    ew[0] = {$urandom, $urandom};
    ew[1] = {$urandom, $urandom};
    ew[2] = 64'hAABBCC0100000000;
    ew[N-1] = 64'h80;
    blk = pack(ew);
    drive_word(ew[0], 1'b0, 4'd0);
    drive_word(ew[1], 1'b0, 4'd0);
    drive_word(64'hAABBCCDDEEFF1122, 1'b1, 4'd3);
    in_ready = 1'b1;
    t = 0; bf_low = 0;
    while (!out_ready && t < 20) begin
      in = {$urandom, $urandom};
      if (buffer_full !== 1'b1) bf_low++;
      step();
      t++;
    end
    in_ready = 1'b0;
    n_cmp++;
    if (t != 6) begin n_err++; $display("FAIL pad_cycles: got %0d required 6", t); end
    n_cmp++;
    if (bf_low != 0) begin n_err++; $display("FAIL pad_buffer_full: low in %0d pad cycles, required 0", bf_low); end
    n_cmp++;
    if (out !== blk) begin n_err++; $display("FAIL pad_data: got %h required %h", out, blk); end
    n_cmp++;
    if (last_block !== 1'b1) begin n_err++; $display("FAIL pad_last: got %b required 1", last_block); end
    f_ack = 1'b1; step(); f_ack = 1'b0;
    n_cmp++;
    if (buffer_full !== 1'b0 || last_block !== 1'b0) begin
      n_err++; $display("FAIL pad_release: buffer_full=%b last_block=%b required 0/0", buffer_full, last_block);
    end
  endtask

  // Empty tail as the ninth word: 0x01 and 0x80 share one word, straight to DONE.
  task automatic test_last_at_end();
    logic [IW-1:0]   ew [N];
    logic [RATE-1:0] blk;
    for (int i = 0; i < N - 1; i++) begin
      ew[i] = {$urandom, $urandom};
      drive_word(ew[i], 1'b0, 4'd0);
    end
    ew[N-1] = 64'h0100000000000080;
    blk = pack(ew);
    drive_word({$urandom, $urandom}, 1'b1, 4'd0);
    n_cmp++;
    if (out_ready !== 1'b1 || last_block !== 1'b1) begin
      n_err++; $display("FAIL end_flags: out_ready=%b last_block=%b required 1/1", out_ready, last_block);
    end
    n_cmp++;
    if (out[IW-1:0] !== 64'h0100000000000080) begin
      n_err++; $display("FAIL end_word: got %h required 0100000000000080", out[IW-1:0]);
    end
    n_cmp++;
    if (out !== blk) begin n_err++; $display("FAIL end_data: got %h required %h", out, blk); end
    f_ack = 1'b1; step(); f_ack = 1'b0;
    n_cmp++;
    if (buffer_full !== 1'b0) begin n_err++; $display("FAIL end_release: buffer_full=%b required 0", buffer_full); end
  endtask

  // Reset between clock edges in the middle of padding, then a fresh message.
  task automatic test_reset_mid_pad();
    logic [IW-1:0] lw;
    int            t;
    drive_word({$urandom, $urandom}, 1'b0, 4'd0);
    drive_word({$urandom, $urandom}, 1'b0, 4'd0);
    drive_word({$urandom, $urandom}, 1'b1, 4'd1);
    step();
    step();
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (out !== '0) begin n_err++; $display("FAIL midreset_out: got %h required 0", out); end
    n_cmp++;
    if (buffer_full !== 1'b0 || out_ready !== 1'b0 || last_block !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_flags: buffer_full=%b out_ready=%b last_block=%b required 0/0/0", buffer_full, out_ready, last_block);
    end
    #3 reset_n = 1'b1;
    step();
    msg_q = {};
    msg_q.push_back({$urandom, $urandom});
    lw = {$urandom, $urandom};
    build_expected(lw, 2);
    drive_word(msg_q[0], 1'b0, 4'd0);
    drive_word(lw, 1'b1, 4'd2);
    t = 0;
    while (!out_ready && t < 20) begin step(); t++; end
    n_cmp++;
    if (out !== exp_blk[0] || last_block !== 1'b1) begin
      n_err++; $display("FAIL midreset_recover: out=%h last=%b required %h/1", out, last_block, exp_blk[0]);
    end
    f_ack = 1'b1; step(); f_ack = 1'b0;
  endtask

  task automatic test_random();
    int            k;
    int            bn;
    int            leak;
    logic [IW-1:0] lw;
    for (int m = 0; m < 14; m++) begin
      k  = $urandom_range(0, 40);
      bn = $urandom_range(0, 15);
      if (m == 0) begin k = 0;  bn = 0;  end
      if (m == 1) begin k = 8;  bn = 11; end
      if (m == 2) begin k = 9;  bn = 7;  end
      if (m == 3) begin k = 17; bn = 5;  end
      lw = {$urandom, $urandom};
      msg_q = {};
      for (int i = 0; i < k; i++) msg_q.push_back({$urandom, $urandom});
      build_expected(lw, bn);
      fork
        begin
          foreach (msg_q[i]) begin
            idle_gap();
            drive_word(msg_q[i], 1'b0, 4'($urandom_range(0, 15)));
          end
          idle_gap();
          drive_word(lw, 1'b1, 4'(bn));
        end
        consume_blocks(exp_blk.size());
      join
    end
    leak = 0;
    repeat (20) begin
      step();
      if (out_ready !== 1'b0) leak++;
    end
    n_cmp++;
    if (leak != 0) begin n_err++; $display("FAIL random_extra_block: out_ready high %0d cycles, required 0", leak); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_block();
    test_pad();
    test_last_at_end();
    test_reset_mid_pad();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
